agc_gain_stage: RTL and testbench
=================================

# agc_gain_stage

Closing half of the AGC loop. Consumes the filtered magnitude estimate from the level-detector/EMA path, integrates the error against the reference into a gain word, and applies that gain to the I/Q sample stream with rounding and saturation. It sits after the detector in the loop and drives the downstream channel interface. It also reports loop lock.

## Interface
- W_IN, 16, I/Q input sample width (signed)
- W_OUT, 16, I/Q output sample width (signed)
- W_ALPHA, 16 / F_ALPHA, 14, loop-speed coefficient width / fraction bits (unsigned)
- W_REF, 16 / F_REF, 14, reference and level width / fraction bits (unsigned)
- W_GAIN, 16 / F_GAIN, 12, gain word width / fraction bits (unsigned); unity = 1<<F_GAIN
- GAIN_MIN, 256 / GAIN_MAX, 32767, gain clamp limits (raw gain codes)
- LOCK_TOL, 256, lock tolerance on |error| (F_REF units); LOCK_CNT, 4, consecutive in-tolerance updates to declare lock
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_alpha  in  W_ALPHA  loop speed
- i_reference  in  W_REF  target level
- s_level_data  in  W_REF  filtered level from detector
- s_level_valid  in  1  level qualifier, one update per asserted cycle
- s_chans_dataI / s_chans_dataQ  in  W_IN  input samples
- s_chans_valid  in  1  sample qualifier
- m_chans_dataI / m_chans_dataQ  out  W_OUT  gained samples
- m_chans_valid  out  1  output qualifier
- o_gain  out  W_GAIN  current gain word
- o_locked  out  1  loop lock flag

## Operation
- Reset values: o_gain = 1<<F_GAIN; m_chans_dataI/Q = 0; m_chans_valid = 0; o_locked = 0; all pipeline valids cleared; FSM = ACQUIRE.
- Gain update, 2 stages:
  - U1 registers err = ref − level as a signed W_REF+1 value and prod = err·alpha.
  - U2 computes gain + (prod >>> (F_ALPHA+F_REF−F_GAIN)), arithmetic shift, truncation. Intermediate math is W_GAIN+2 signed, then clamped to [GAIN_MIN, GAIN_MAX].
  - Back-to-back level valids are all applied in order. No stall, no drop.
- Sample path, 3 stages:
  - S1 registers I, Q and a snapshot of o_gain.
  - S2 computes the signed product sample·gain at W_IN+W_GAIN+1 bits.
  - S3 adds 1<<(F_GAIN−1) (round half toward +inf), shifts >>> F_GAIN, and saturates to [−2^(W_OUT−1), 2^(W_OUT−1)−1].
  - Samples with valid low do not advance the output registers. m_chans_data holds its last value.
- Lock FSM, updated on each U1 result:
  - ACQUIRE: if |err| ≤ LOCK_TOL, increment the counter; otherwise clear it. When the counter reaches LOCK_CNT, go to TRACK.
  - TRACK: o_locked = 1. One update with |err| > LOCK_TOL clears the counter and returns to ACQUIRE, with o_locked = 0 the next cycle.
- Level and sample valid in the same cycle: the sample uses the pre-update gain. The new gain affects samples accepted ≥2 cycles after the level valid.
- Reset asserted mid-operation: all state returns to reset values immediately and in-flight samples are discarded. No m_chans_valid pulse follows reset deassertion until new input arrives.

## Timing
- Sample latency is 3 cycles: s_chans_valid at cycle n produces m_chans_valid at n+3. Throughput is 1 sample/cycle.
- Gain latency is 2 cycles: s_level_valid at n updates o_gain, visible at n+2.
- Lock latency: o_locked rises 1 cycle after the LOCK_CNT-th in-tolerance U1 result.
- There is no backpressure, and the downstream side must accept every cycle.

## Configuration
- AGC_GAIN_FREEZE_EN defined: adds input i_freeze (1 bit). While i_freeze = 1, U2 holds o_gain, the lock FSM holds its state, and the sample path is unaffected.
- AGC_GAIN_FREEZE_EN undefined: there is no port and the gain always updates.

## Structure
- Shared package agc_pkg holds:
  - width/fraction defaults and the unity-gain constant;
  - the lock FSM state typedef (ACQUIRE, TRACK);
  - a saturate function (signed in, W_OUT out).
- Sub-module agc_sat_mul (multiply, round, saturate, 2 internal register stages) is instantiated once for I and once for Q. The top holds S1, the update pipeline and the FSM.

## Test plan
- Unity pass-through: after reset, gain = 4096. I = 1000, Q = −1000 at cycle n produces m_chans_valid at n+3 with I = 1000, Q = −1000.
- Gain step: ref = 8192, level = 4096, alpha = 16384 for a single valid. o_gain goes 4096 → 5120 two cycles later.
- Saturation: with gain 5120, I = 30000 and Q = −30000 give I = 32767 and Q = −32768. Level = 0 repeated drives the gain to clamp at GAIN_MAX = 32767 and no further.
- Rounding: gain 6144. I = 1 gives 2, I = −1 gives −1, I = 3 gives 5 (4.5 rounds up).
- Lock: level = reference ± 100 for 4 valids sets o_locked. One level at reference − 1000 clears it the cycle after U1. Four further in-tolerance valids re-lock.
- Reset mid-stream: assert reset with 2 samples in flight and gain = 5120. No m_chans_valid appears, o_gain = 4096 and o_locked = 0 immediately. Normal operation resumes after release.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared definitions for the AGC gain stage: widths, fraction points, gain
// clamp and lock limits, the lock FSM state type and the output saturator.
package agc_pkg;

    localparam int W_IN     = 16;
    localparam int W_OUT    = 16;
    localparam int W_ALPHA  = 16;
    localparam int F_ALPHA  = 14;
    localparam int W_REF    = 16;
    localparam int F_REF    = 14;
    localparam int W_GAIN   = 16;
    localparam int F_GAIN   = 12;

    localparam int GAIN_MIN = 256;
    localparam int GAIN_MAX = 32767;
    localparam int LOCK_TOL = 256;
    localparam int LOCK_CNT = 4;

    localparam logic [W_GAIN-1:0] GAIN_UNITY = W_GAIN'(1 << F_GAIN);

    // sample * gain product, plus one bit of headroom for the rounding add
    localparam int PROD_W    = W_IN + W_GAIN + 1;
    localparam int SUM_W     = PROD_W + 1;
    // signed loop error and its product with the (zero-extended) alpha
    localparam int ERR_W     = W_REF + 1;
    localparam int UPD_W     = ERR_W + W_ALPHA + 1;
    localparam int UPD_SHIFT = F_ALPHA + F_REF - F_GAIN;
    // gain update arithmetic, wide enough to hold gain + largest step
    localparam int GSUM_W    = W_GAIN + 2;
    localparam int CNT_W     = $clog2(LOCK_CNT + 1);

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } lock_state_t;

    localparam logic signed [SUM_W-1:0] OUT_MAX_EXT = SUM_W'((2 ** (W_OUT - 1)) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN_EXT = -SUM_W'(2 ** (W_OUT - 1));

    // Clip a wide signed value into the signed output range.
    function automatic logic signed [W_OUT-1:0] sat_out(input logic signed [SUM_W-1:0] v);
        if (v > OUT_MAX_EXT) begin
            return W_OUT'(OUT_MAX_EXT);
        end else if (v < OUT_MIN_EXT) begin
            return W_OUT'(OUT_MIN_EXT);
        end else begin
            return W_OUT'(v);
        end
    endfunction

endpackage

// File: rtl/agc_gain_stage_if.sv
// Level input, I/Q sample input and gained I/Q output of the AGC gain stage.
// master = the side driving levels/samples and receiving the gained stream,
// slave  = the gain stage itself.
interface agc_gain_stage_if;
    import agc_pkg::*;

    logic [W_REF-1:0]        s_level_data;
    logic                    s_level_valid;

    logic signed [W_IN-1:0]  s_chans_dataI;
    logic signed [W_IN-1:0]  s_chans_dataQ;
    logic                    s_chans_valid;

    logic signed [W_OUT-1:0] m_chans_dataI;
    logic signed [W_OUT-1:0] m_chans_dataQ;
    logic                    m_chans_valid;

    modport master (
        output s_level_data, s_level_valid,
        output s_chans_dataI, s_chans_dataQ, s_chans_valid,
        input  m_chans_dataI, m_chans_dataQ, m_chans_valid
    );

    modport slave (
        input  s_level_data, s_level_valid,
        input  s_chans_dataI, s_chans_dataQ, s_chans_valid,
        output m_chans_dataI, m_chans_dataQ, m_chans_valid
    );

endinterface

// File: rtl/agc_sat_mul.sv
// One channel of the gain multiply: registered signed product, then
// round-half-up, shift back to the sample scale and saturate.
// Data registers only move on a valid, so the output holds between samples.
module agc_sat_mul
    import agc_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [W_IN-1:0]   sample,
    input  logic [W_GAIN-1:0]        gain,
    output logic                     out_valid,
    output logic signed [W_OUT-1:0]  out_data
);

    localparam logic signed [SUM_W-1:0] ROUND_BIAS = SUM_W'(1 << (F_GAIN - 1));

    logic signed [PROD_W-1:0] prod_s2;
    logic                     vld_s2;
    logic signed [SUM_W-1:0]  round_sum;
    logic signed [SUM_W-1:0]  scaled;

    // S2: signed sample times unsigned gain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_s2  <= 1'b0;
            prod_s2 <= '0;
        end else begin
            vld_s2 <= in_valid;
            if (in_valid) begin
                prod_s2 <= PROD_W'(sample) * PROD_W'($signed({1'b0, gain}));
            end
        end
    end

    // rounding add and arithmetic shift back to the sample scale
    always_comb begin
        round_sum = SUM_W'(prod_s2) + ROUND_BIAS;
        scaled    = round_sum >>> F_GAIN;
    end

    // S3: saturated output, held while no sample arrives
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= vld_s2;
            if (vld_s2) begin
                out_data <= sat_out(scaled);
            end
        end
    end

endmodule

// File: rtl/agc_gain_stage.sv
// AGC gain stage: integrates (reference - level) * alpha into the gain word,
// applies the gain to the I/Q stream and reports loop lock.
// Optional build macro AGC_GAIN_FREEZE_EN adds i_freeze, which holds the gain
// word and the lock FSM while the sample path keeps running.
//
// Lock FSM states:
//   state   | meaning
//   ACQUIRE | counting consecutive in-tolerance errors, o_locked = 0
//   TRACK   | loop locked, o_locked = 1; one out-of-tolerance error drops back
module agc_gain_stage
    import agc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
`ifdef AGC_GAIN_FREEZE_EN
    input  logic                i_freeze,
`endif
    input  logic [W_ALPHA-1:0]  i_alpha,
    input  logic [W_REF-1:0]    i_reference,
    agc_gain_stage_if.slave     chans,
    output logic [W_GAIN-1:0]   o_gain,
    output logic                o_locked
);

    logic freeze;
`ifdef AGC_GAIN_FREEZE_EN
    assign freeze = i_freeze;
`else
    assign freeze = 1'b0;
`endif

    // update pipeline
    logic signed [ERR_W-1:0]  err_next;
    logic signed [ERR_W-1:0]  err_u1;
    logic signed [UPD_W-1:0]  prod_u1;
    logic                     vld_u1;
    logic signed [GSUM_W-1:0] gain_delta;
    logic signed [GSUM_W-1:0] gain_sum;
    logic [W_GAIN-1:0]        gain_clamped;

    // lock detection
    logic [ERR_W-1:0]         err_abs;
    logic                     in_tol;
    lock_state_t              state;
    logic [CNT_W-1:0]         lock_cnt;

    // sample path front register
    logic signed [W_IN-1:0]   i_s1;
    logic signed [W_IN-1:0]   q_s1;
    logic [W_GAIN-1:0]        gain_s1;
    logic                     vld_s1;
    logic                     vld_i;
    logic                     vld_q;

    assign err_next = $signed({1'b0, i_reference}) - $signed({1'b0, chans.s_level_data});

    // U1: register loop error and its product with alpha
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_u1  <= 1'b0;
            err_u1  <= '0;
            prod_u1 <= '0;
        end else begin
            vld_u1 <= chans.s_level_valid;
            if (chans.s_level_valid) begin
                err_u1  <= err_next;
                prod_u1 <= UPD_W'(err_next) * UPD_W'($signed({1'b0, i_alpha}));
            end
        end
    end

    // step = product rescaled to gain fraction bits (floor), then clamped
    always_comb begin
        gain_delta   = GSUM_W'(prod_u1 >>> UPD_SHIFT);
        gain_sum     = $signed({2'b00, o_gain}) + gain_delta;
        gain_clamped = W_GAIN'(gain_sum);
        if (gain_sum < GSUM_W'(GAIN_MIN)) begin
            gain_clamped = W_GAIN'(GAIN_MIN);
        end else if (gain_sum > GSUM_W'(GAIN_MAX)) begin
            gain_clamped = W_GAIN'(GAIN_MAX);
        end
    end

    // U2: commit the clamped gain word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_gain <= GAIN_UNITY;
        end else if (vld_u1 && !freeze) begin
            o_gain <= gain_clamped;
        end
    end

    // |err| against the lock tolerance
    always_comb begin
        err_abs = err_u1[ERR_W-1] ? ERR_W'(-err_u1) : ERR_W'(err_u1);
        in_tol  = (err_abs <= ERR_W'(LOCK_TOL));
    end

    // lock FSM, advanced once per U1 result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ACQUIRE;
            lock_cnt <= '0;
            o_locked <= 1'b0;
        end else if (vld_u1 && !freeze) begin
            case (state)
                ACQUIRE: begin
                    if (!in_tol) begin
                        lock_cnt <= '0;
                    end else if (lock_cnt == CNT_W'(LOCK_CNT - 1)) begin
                        state    <= TRACK;
                        o_locked <= 1'b1;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                TRACK: begin
                    if (!in_tol) begin
                        state    <= ACQUIRE;
                        o_locked <= 1'b0;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ACQUIRE;
                    o_locked <= 1'b0;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    // S1: capture samples with the gain in force at acceptance time
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_s1  <= 1'b0;
            i_s1    <= '0;
            q_s1    <= '0;
            gain_s1 <= GAIN_UNITY;
        end else begin
            vld_s1 <= chans.s_chans_valid;
            if (chans.s_chans_valid) begin
                i_s1    <= chans.s_chans_dataI;
                q_s1    <= chans.s_chans_dataQ;
                gain_s1 <= o_gain;
            end
        end
    end

    agc_sat_mul u_mul_i (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (vld_s1),
        .sample    (i_s1),
        .gain      (gain_s1),
        .out_valid (vld_i),
        .out_data  (chans.m_chans_dataI)
    );

    agc_sat_mul u_mul_q (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (vld_s1),
        .sample    (q_s1),
        .gain      (gain_s1),
        .out_valid (vld_q),
        .out_data  (chans.m_chans_dataQ)
    );

    // both lanes run in lockstep; combining keeps either valid from dangling
    assign chans.m_chans_valid = vld_i & vld_q;

endmodule

// File: tb/tb_agc_gain_stage.sv
// Directed bench for agc_gain_stage: pass-through, gain steps, clamping,
// rounding, saturation, lock/unlock and asynchronous reset mid-stream.
module tb_agc_gain_stage;
    import agc_pkg::*;

    logic               clk;
    logic               reset;
    logic [W_ALPHA-1:0] alpha;
    logic [W_REF-1:0]   reference;
    logic [W_GAIN-1:0]  o_gain;
    logic               o_locked;
`ifdef AGC_GAIN_FREEZE_EN
    logic               freeze;
`endif

    int n_chk = 0;
    int n_bad = 0;
    int ghost = 0;

    agc_gain_stage_if chans ();

    agc_gain_stage dut (
        .clk         (clk),
        .reset       (reset),
`ifdef AGC_GAIN_FREEZE_EN
        .i_freeze    (freeze),
`endif
        .i_alpha     (alpha),
        .i_reference (reference),
        .chans       (chans.slave),
        .o_gain      (o_gain),
        .o_locked    (o_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        chans.s_level_valid = 1'b0;
        chans.s_chans_valid = 1'b0;
    endtask

    task automatic drive_level(input logic [W_REF-1:0] lvl);
        chans.s_level_data  = lvl;
        chans.s_level_valid = 1'b1;
        @(negedge clk);
        chans.s_level_valid = 1'b0;
    endtask

    task automatic drive_sample(input logic signed [W_IN-1:0] si, input logic signed [W_IN-1:0] sq);
        chans.s_chans_dataI = si;
        chans.s_chans_dataQ = sq;
        chans.s_chans_valid = 1'b1;
        @(negedge clk);
        chans.s_chans_valid = 1'b0;
    endtask

    // single sample: silent for two cycles, valid on the third, then held
    task automatic sample_check(input string tag, input logic signed [W_IN-1:0] si,
                                input logic signed [W_IN-1:0] sq,
                                input int ei, input int eq);
        drive_sample(si, sq);
        chk({tag, "_lat1"}, chans.m_chans_valid, 0);
        @(negedge clk);
        chk({tag, "_lat2"}, chans.m_chans_valid, 0);
        @(negedge clk);
        chk({tag, "_vld"}, chans.m_chans_valid, 1);
        chk({tag, "_i"}, chans.m_chans_dataI, ei);
        chk({tag, "_q"}, chans.m_chans_dataQ, eq);
        @(negedge clk);
        chk({tag, "_vld_off"}, chans.m_chans_valid, 0);
        chk({tag, "_hold_i"}, chans.m_chans_dataI, ei);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        alpha = '0;
        reference = '0;
`ifdef AGC_GAIN_FREEZE_EN
        freeze = 1'b0;
`endif
        chans.s_level_data  = '0;
        chans.s_chans_dataI = '0;
        chans.s_chans_dataQ = '0;
        idle();
        repeat (3) @(negedge clk);

        chk("rst_gain", o_gain, 4096);
        chk("rst_lock", o_locked, 0);
        chk("rst_mvalid", chans.m_chans_valid, 0);
        chk("rst_mi", chans.m_chans_dataI, 0);
        chk("rst_mq", chans.m_chans_dataQ, 0);
        reset = 1'b1;
        @(negedge clk);

        // unity pass-through
        sample_check("unity", 16'sd1000, -16'sd1000, 1000, -1000);

        // single gain step: err 4096 * alpha 1.0 -> +1024
        reference = 16'd8192;
        alpha = 16'd16384;
        drive_level(16'd4096);
        chk("step_gain_n1", o_gain, 4096);
        @(negedge clk);
        chk("step_gain_n2", o_gain, 5120);

        // saturation at gain 1.25
        sample_check("sat", 16'sd30000, -16'sd30000, 32767, -32768);

        // back-to-back level updates, alpha 0.5 -> +512 each
        alpha = 16'd8192;
        drive_level(16'd4096);
        drive_level(16'd4096);
        chk("b2b_gain_1", o_gain, 5632);
        @(negedge clk);
        chk("b2b_gain_2", o_gain, 6144);

        // rounding burst at gain 1.5, one sample per cycle
        drive_sample(16'sd1, 16'sd0);
        drive_sample(-16'sd1, 16'sd0);
        drive_sample(16'sd3, 16'sd0);
        chk("rnd_vld_a", chans.m_chans_valid, 1);
        chk("rnd_p1", chans.m_chans_dataI, 2);
        chk("rnd_q", chans.m_chans_dataQ, 0);
        @(negedge clk);
        chk("rnd_vld_b", chans.m_chans_valid, 1);
        chk("rnd_m1", chans.m_chans_dataI, -1);
        @(negedge clk);
        chk("rnd_p3", chans.m_chans_dataI, 5);
        @(negedge clk);
        chk("rnd_vld_off", chans.m_chans_valid, 0);
        @(negedge clk);
        chk("rnd_hold", chans.m_chans_dataI, 5);

        // level and sample together: the first two samples see the old gain
        alpha = 16'd16384;
        chans.s_level_data  = 16'd4096;
        chans.s_level_valid = 1'b1;
        chans.s_chans_dataI = 16'sd4096;
        chans.s_chans_dataQ = 16'sd0;
        chans.s_chans_valid = 1'b1;
        @(negedge clk);
        chans.s_level_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        idle();
        chk("same_a", chans.m_chans_dataI, 6144);
        @(negedge clk);
        chk("same_b", chans.m_chans_dataI, 6144);
        @(negedge clk);
        chk("same_c", chans.m_chans_dataI, 7168);
        chk("same_gain", o_gain, 7168);

        // drive gain into the upper clamp
        reference = 16'd16384;
        alpha = 16'd65535;
        drive_level(16'd0);
        drive_level(16'd0);
        chk("clamp_hi_step", o_gain, 23551);
        drive_level(16'd0);
        drive_level(16'd0);
        @(negedge clk);
        chk("clamp_hi", o_gain, 32767);

        // and into the lower clamp
        reference = 16'd0;
        drive_level(16'd65535);
        @(negedge clk);
        chk("clamp_lo", o_gain, 256);
        drive_level(16'd65535);
        @(negedge clk);
        chk("clamp_lo_hold", o_gain, 256);

        // lock counter must restart after an out-of-tolerance error
        alpha = 16'd0;
        reference = 16'd8192;
        drive_level(16'd8192);
        drive_level(16'd8192);
        drive_level(16'd8192);
        drive_level(16'd9000);
        drive_level(16'd8192);
        drive_level(16'd8192);
        drive_level(16'd8192);
        drive_level(16'd9000);
        @(negedge clk);
        chk("lock_restart", o_locked, 0);

        // lock after four in-tolerance updates
        drive_level(16'd8292);
        drive_level(16'd8092);
        drive_level(16'd8292);
        drive_level(16'd8092);
        chk("lock_pre", o_locked, 0);
        @(negedge clk);
        chk("lock_set", o_locked, 1);

        // one large error drops lock the cycle after U1
        drive_level(16'd7192);
        chk("unlock_pre", o_locked, 1);
        @(negedge clk);
        chk("unlock", o_locked, 0);

        // re-lock, including |err| exactly at the tolerance
        drive_level(16'd8448);
        drive_level(16'd7936);
        drive_level(16'd8192);
        drive_level(16'd8448);
        chk("relock_pre", o_locked, 0);
        @(negedge clk);
        chk("relock", o_locked, 1);
        chk("lock_gain_frozen", o_gain, 256);

        // reset mid-stream: set up gain 1.25 and lock first
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst2_gain", o_gain, 4096);
        alpha = 16'd16384;
        drive_level(16'd4096);
        @(negedge clk);
        chk("rst2_step", o_gain, 5120);
        alpha = 16'd0;
        drive_level(16'd8192);
        drive_level(16'd8192);
        drive_level(16'd8192);
        drive_level(16'd8192);
        @(negedge clk);
        chk("rst2_locked", o_locked, 1);
        drive_sample(16'sd500, 16'sd500);
        drive_sample(16'sd600, 16'sd600);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_gain", o_gain, 4096);
        chk("rst_mid_lock", o_locked, 0);
        chk("rst_mid_mvalid", chans.m_chans_valid, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (chans.m_chans_valid) ghost++;
        end
        chk("rst_no_ghost", ghost, 0);
        chk("rst_after_gain", o_gain, 4096);

        sample_check("resume", 16'sd1000, -16'sd1000, 1000, -1000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
